// File: rtl/mau_pkg.sv
// Shared op-code constants, FSM state encoding and op decode helpers for mem_access_unit.
package mau_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } mau_state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  function automatic logic op_is_subword_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic w_half;
    logic w_word;
    w_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    w_word = (op == OP_LW) || (op == OP_SW);
    return (w_half && lo[0]) || (w_word && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mau_lane
  import mau_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_bsh  = {i_addr_lo, 3'b000};
    w_hsh  = {i_addr_lo[1], 4'b0000};
    w_byte = 8'(i_word >> w_bsh);
    w_half = 16'(i_word >> w_hsh);

    case (i_op)
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load = {24'd0, w_byte};
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load = {16'd0, w_half};
      OP_LW:   o_load = i_word;
      default: o_load = '0;
    endcase

    case (i_op)
      OP_SB:   o_store = (i_word & ~(32'h0000_00FF << w_bsh)) |
                         ({24'd0, i_wdata[7:0]} << w_bsh);
      OP_SH:   o_store = (i_word & ~(32'h0000_FFFF << w_hsh)) |
                         ({16'd0, i_wdata[15:0]} << w_hsh);
      OP_SW:   o_store = i_wdata;
      default: o_store = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory with sub-word read-modify-write.
// Define MAU_TRACE_EN to print memory write and fault trace lines.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic        mau_clk,
  input  logic        mau_reset,
  input  logic [31:0] mau_pc,
  input  logic        mau_req_valid,
  output logic        mau_req_ready,
  input  logic [3:0]  mau_op,
  input  logic [31:0] mau_addr,
  input  logic [31:0] mau_wdata,
  output logic        mau_done,
  output logic [31:0] mau_rdata,
  output logic        mau_exc,
  output logic [31:0] mau_mem_addr,
  output logic        mau_mem_we,
  output logic [31:0] mau_mem_wdata,
  input  logic [31:0] mau_mem_rdata
);

  mau_state_e  r_state;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_exc;
  logic        r_done;
  logic        r_ready;
  logic        r_mem_we;
`ifdef MAU_TRACE_EN
  logic [31:0] r_pc;
`endif

  logic        w_range_fault;
  logic        w_fault;
  logic        w_busy;
  logic [31:0] w_lane_word;
  logic [31:0] w_load;
  logic [31:0] w_store;

  assign w_range_fault = (mau_addr >> ADDR_BITS) != 32'd0;
  assign w_fault       = !op_is_legal(mau_op) || op_misaligned(mau_op, mau_addr[1:0]) ||
                         w_range_fault;
  assign w_busy        = (r_state == ST_ACCESS) || (r_state == ST_MERGE);

  // In MERGE the lane works on the old word latched during ACCESS.
  assign w_lane_word   = (r_state == ST_MERGE) ? r_old : mau_mem_rdata;

  mau_lane u_lane (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (w_lane_word),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_store   (w_store)
  );

  assign mau_req_ready = r_ready;
  assign mau_done      = r_done;
  assign mau_rdata     = r_rdata;
  assign mau_exc       = r_exc;
  assign mau_mem_we    = r_mem_we;
  assign mau_mem_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mau_mem_wdata = r_mem_we ? w_store : 32'd0;

  always_ff @(posedge mau_clk or posedge mau_reset) begin
    if (mau_reset) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_rdata  <= '0;
      r_exc    <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_mem_we <= 1'b0;
`ifdef MAU_TRACE_EN
      r_pc     <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_exc   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (mau_req_valid) begin
            r_op    <= mau_op;
            r_addr  <= mau_addr;
            r_wdata <= mau_wdata;
            r_ready <= 1'b0;
`ifdef MAU_TRACE_EN
            r_pc    <= mau_pc;
`endif
            if (w_fault) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_exc   <= 1'b1;
`ifdef MAU_TRACE_EN
              $display("@%h:fault %h", mau_pc, mau_addr);
`endif
            end else begin
              r_state  <= ST_ACCESS;
              r_mem_we <= (mau_op == OP_SW);
            end
          end
        end
        ST_ACCESS: begin
          if (op_is_subword_store(r_op)) begin
            r_old    <= mau_mem_rdata;
            r_mem_we <= 1'b1;
            r_state  <= ST_MERGE;
          end else begin
`ifdef MAU_TRACE_EN
            if (r_mem_we) begin
              $display("@%h:*%h<=%h", r_pc, {r_addr[31:2], 2'b00}, w_store);
            end
`endif
            r_mem_we <= 1'b0;
            r_rdata  <= op_is_load(r_op) ? w_load : 32'd0;
            r_done   <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_MERGE: begin
`ifdef MAU_TRACE_EN
          $display("@%h:*%h<=%h", r_pc, {r_addr[31:2], 2'b00}, w_store);
`endif
          r_mem_we <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops vs a reference model.
module tb_mem_access_unit;

  logic        mau_clk = 1'b0;
  logic        mau_reset;
  logic [31:0] mau_pc;
  logic        mau_req_valid;
  logic        mau_req_ready;
  logic [3:0]  mau_op;
  logic [31:0] mau_addr;
  logic [31:0] mau_wdata;
  logic        mau_done;
  logic [31:0] mau_rdata;
  logic        mau_exc;
  logic [31:0] mau_mem_addr;
  logic        mau_mem_we;
  logic [31:0] mau_mem_wdata;
  logic [31:0] mau_mem_rdata;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_BITS(12)) dut (
    .mau_clk       (mau_clk),
    .mau_reset     (mau_reset),
    .mau_pc        (mau_pc),
    .mau_req_valid (mau_req_valid),
    .mau_req_ready (mau_req_ready),
    .mau_op        (mau_op),
    .mau_addr      (mau_addr),
    .mau_wdata     (mau_wdata),
    .mau_done      (mau_done),
    .mau_rdata     (mau_rdata),
    .mau_exc       (mau_exc),
    .mau_mem_addr  (mau_mem_addr),
    .mau_mem_we    (mau_mem_we),
    .mau_mem_wdata (mau_mem_wdata),
    .mau_mem_rdata (mau_mem_rdata)
  );

  always #5 mau_clk = ~mau_clk;

  always @(posedge mau_clk) begin
    if (mau_mem_we) mem[mau_mem_addr[11:2]] <= mau_mem_wdata;
  end
  assign mau_mem_rdata = mem[mau_mem_addr[11:2]];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the op rules, using arithmetic on lanes.
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] old, output logic exc, output logic [31:0] rd,
                       output logic [31:0] nw, output int lat, output int nwe);
    logic        legal, half, word;
    int unsigned bsh, hsh;
    logic [31:0] b, h;
    legal = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    half  = op inside {4'd1, 4'd5, 4'd9};
    word  = op inside {4'd2, 4'd10};
    exc   = !legal || (half && (addr % 2 != 0)) || (word && (addr % 4 != 0)) ||
            (addr >= 32'h1000);
    bsh   = 8 * (addr % 4);
    hsh   = 16 * ((addr / 2) % 2);
    b     = (old >> bsh) % 256;
    h     = (old >> hsh) % 65536;
    rd    = 32'd0;
    nw    = old;
    nwe   = 0;
    lat   = 2;
    case (op)
      4'd0:  rd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4'd1:  rd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4'd2:  rd = old;
      4'd4:  rd = b;
      4'd5:  rd = h;
      4'd8:  begin nw = old - (b << bsh) + ((wd % 256) << bsh); nwe = 1; lat = 3; end
      4'd9:  begin nw = old - (h << hsh) + ((wd % 65536) << hsh); nwe = 1; lat = 3; end
      4'd10: begin nw = wd; nwe = 1; end
      default: ;
    endcase
    if (exc) begin
      rd  = 32'd0;
      nw  = old;
      nwe = 0;
      lat = 1;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] got_rd);
    logic        e_exc, got_exc, seen;
    logic [31:0] e_rd, e_nw;
    int          e_lat, e_nwe, lat, nwe;
    model(op, addr, wd, ref_mem[addr[11:2]], e_exc, e_rd, e_nw, e_lat, e_nwe);
    @(negedge mau_clk);
    check_eq({tag, "_ready"}, {31'd0, mau_req_ready}, 32'd1);
    mau_req_valid = 1'b1;
    mau_op        = op;
    mau_addr      = addr;
    mau_wdata     = wd;
    mau_pc        = $urandom;
    @(posedge mau_clk);
    #1;
    mau_req_valid = 1'b0;
    mau_op        = 4'($urandom);
    mau_addr      = $urandom;
    mau_wdata     = $urandom;
    seen    = 1'b0;
    lat     = 0;
    nwe     = 0;
    got_rd  = 32'd0;
    got_exc = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge mau_clk);
      if (mau_mem_we) begin
        nwe++;
        check_eq({tag, "_we_addr"}, mau_mem_addr, {addr[31:2], 2'b00});
        check_eq({tag, "_we_data"}, mau_mem_wdata, e_nw);
      end
      if (mau_done) begin
        seen    = 1'b1;
        lat     = i;
        got_rd  = mau_rdata;
        got_exc = mau_exc;
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_lat"}, lat, e_lat);
    check_eq({tag, "_exc"}, {31'd0, got_exc}, {31'd0, e_exc});
    check_eq({tag, "_rdata"}, got_rd, e_rd);
    check_eq({tag, "_nwe"}, nwe, e_nwe);
    ref_mem[addr[11:2]] = e_nw;
    check_eq({tag, "_memword"}, mem[addr[11:2]], e_nw);
    @(negedge mau_clk);
    check_eq({tag, "_done_pulse"}, {31'd0, mau_done}, 32'd0);
  endtask

  logic [3:0]  op_tab [11] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd3, 4'd7, 4'd15};
  logic [31:0] rd;
  logic [31:0] a;
  int          we_cyc[$];
  int          dones;
  logic        gap_ok;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    mau_reset     = 1'b1;
    mau_req_valid = 1'b0;
    mau_op        = 4'd0;
    mau_addr      = 32'd0;
    mau_wdata     = 32'd0;
    mau_pc        = 32'd0;
    repeat (2) @(negedge mau_clk);
    check_eq("rst_ready", {31'd0, mau_req_ready}, 32'd1);
    check_eq("rst_done", {31'd0, mau_done}, 32'd0);
    check_eq("rst_exc", {31'd0, mau_exc}, 32'd0);
    check_eq("rst_rdata", mau_rdata, 32'd0);
    check_eq("rst_we", {31'd0, mau_mem_we}, 32'd0);
    check_eq("rst_maddr", mau_mem_addr, 32'd0);
    check_eq("rst_mwdata", mau_mem_wdata, 32'd0);
    mau_reset = 1'b0;

    for (int w = 0; w < 32; w++) do_op("seed", 4'd10, 32'(w * 4), $urandom, rd);

    do_op("sw10", 4'd10, 32'h10, 32'hDEAD_BEEF, rd);
    do_op("lw10", 4'd2, 32'h10, 32'h0, rd);
    check_eq("lw10_lit", rd, 32'hDEAD_BEEF);
    do_op("sw20", 4'd10, 32'h20, 32'h80FF_7F01, rd);
    do_op("lb20", 4'd0, 32'h20, 32'h0, rd);
    check_eq("lb20_lit", rd, 32'h0000_0001);
    do_op("lb23", 4'd0, 32'h23, 32'h0, rd);
    check_eq("lb23_lit", rd, 32'hFFFF_FF80);
    do_op("lbu23", 4'd4, 32'h23, 32'h0, rd);
    check_eq("lbu23_lit", rd, 32'h0000_0080);
    do_op("lh22", 4'd1, 32'h22, 32'h0, rd);
    check_eq("lh22_lit", rd, 32'hFFFF_80FF);
    do_op("lhu22", 4'd5, 32'h22, 32'h0, rd);
    check_eq("lhu22_lit", rd, 32'h0000_80FF);
    do_op("sw30", 4'd10, 32'h30, 32'h1122_3344, rd);
    do_op("sb31", 4'd8, 32'h31, 32'h0000_00AA, rd);
    check_eq("sb31_lit", mem[12], 32'h1122_AA44);
    do_op("sh32", 4'd9, 32'h32, 32'h0000_BEEF, rd);
    check_eq("sh32_lit", mem[12], 32'hBEEF_AA44);
    do_op("f_lw22", 4'd2, 32'h22, 32'h0, rd);
    do_op("f_sh31", 4'd9, 32'h31, 32'h1234, rd);
    do_op("f_lw1000", 4'd2, 32'h1000, 32'h0, rd);
    do_op("f_op3", 4'd3, 32'h10, 32'h0, rd);

    // Reset while an SB sits in MERGE with the write enable high.
    @(negedge mau_clk);
    mau_req_valid = 1'b1;
    mau_op        = 4'd8;
    mau_addr      = 32'h30;
    mau_wdata     = 32'h55;
    @(posedge mau_clk);
    #1;
    mau_req_valid = 1'b0;
    @(posedge mau_clk);
    #1;
    check_eq("mrst_pre_we", {31'd0, mau_mem_we}, 32'd1);
    mau_reset = 1'b1;
    #1;
    check_eq("mrst_we", {31'd0, mau_mem_we}, 32'd0);
    check_eq("mrst_ready", {31'd0, mau_req_ready}, 32'd1);
    @(posedge mau_clk);
    @(negedge mau_clk);
    mau_reset = 1'b0;
    check_eq("mrst_mem", mem[12], 32'hBEEF_AA44);
    do_op("mrst_lw", 4'd2, 32'h30, 32'h0, rd);
    check_eq("mrst_lw_lit", rd, 32'hBEEF_AA44);

    // Two SWs with valid held high.
    @(negedge mau_clk);
    mau_req_valid = 1'b1;
    mau_op        = 4'd10;
    mau_addr      = 32'h40;
    mau_wdata     = 32'hCAFE_0001;
    dones         = 0;
    for (int c = 0; c < 20 && dones < 2; c++) begin
      @(negedge mau_clk);
      if (mau_mem_we) we_cyc.push_back(c);
      if (mau_done) begin
        dones++;
        check_eq("b2b_ready_resp", {31'd0, mau_req_ready}, 32'd0);
        if (dones == 1) begin
          mau_addr  = 32'h44;
          mau_wdata = 32'hCAFE_0002;
        end else begin
          mau_req_valid = 1'b0;
        end
      end
    end
    check_eq("b2b_dones", dones, 32'd2);
    check_eq("b2b_we_cycles", we_cyc.size(), 32'd2);
    gap_ok = 1'b0;
    if (we_cyc.size() == 2) gap_ok = (we_cyc[1] - we_cyc[0]) >= 3;
    check_eq("b2b_gap", {31'd0, gap_ok}, 32'd1);
    ref_mem[16] = 32'hCAFE_0001;
    ref_mem[17] = 32'hCAFE_0002;
    check_eq("b2b_mem0", mem[16], ref_mem[16]);
    check_eq("b2b_mem1", mem[17], ref_mem[17]);

    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      do_op("rnd", op_tab[$urandom_range(0, 10)], a, $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
